// File: rtl/dequant_bs_array.sv
// Multi-lane bit-serial dequantizer: signed lane mantissas times one shared unsigned scale, MSB-first.
// Optional early finish once the remaining lower scale bits are all zero: define DEQUANT_ZERO_SKIP_EN.
module dequant_bs_array #(
  parameter int NUM_LANE      = 4,
  parameter int IN_EXP_WIDTH  = 6,
  parameter int IN_MAN_WIDTH  = 15,
  parameter int SCALE_WIDTH   = 8,
  parameter int OUT_EXP_WIDTH = 6,
  parameter int OUT_MAN_WIDTH = 23
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SCALE_WIDTH-1:0]            scale,
  input  logic                              scale_sign,
  input  logic [$clog2(SCALE_WIDTH+1)-1:0]  scale_prec,
  input  logic [NUM_LANE*IN_EXP_WIDTH-1:0]  in_exp,
  input  logic [NUM_LANE*IN_MAN_WIDTH-1:0]  in_man,
  input  logic [NUM_LANE-1:0]               in_sign,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_LANE*OUT_EXP_WIDTH-1:0] out_exp,
  output logic [NUM_LANE*OUT_MAN_WIDTH-1:0] out_man,
  output logic [NUM_LANE-1:0]               out_sign,
  output logic                              busy
);

  localparam int PW = $clog2(SCALE_WIDTH + 1);
  localparam int CW = (SCALE_WIDTH > 1) ? $clog2(SCALE_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q;
  logic [SCALE_WIDTH-1:0]   scale_q;
  logic [CW-1:0]            cnt_q;
  logic [NUM_LANE-1:0]      sign_q;
  logic [IN_MAN_WIDTH-1:0]  man_q   [NUM_LANE];
  logic [OUT_EXP_WIDTH-1:0] exp_q   [NUM_LANE];
  logic [OUT_MAN_WIDTH-1:0] acc_q   [NUM_LANE];

  logic [PW-1:0]            p_eff_d;
  logic [CW-1:0]            cnt_d;
  logic [OUT_MAN_WIDTH-1:0] acc_d   [NUM_LANE];
  logic                     skip;

  // A precision of zero or beyond the scale width selects the full scale width.
  always_comb begin
    p_eff_d = scale_prec;
    if (scale_prec == '0 || scale_prec > PW'(SCALE_WIDTH))
      p_eff_d = PW'(SCALE_WIDTH);
    cnt_d = CW'(p_eff_d - PW'(1));
  end

  always_comb begin
    for (int i = 0; i < NUM_LANE; i++) begin
      acc_d[i] = (acc_q[i] << 1) +
                 (scale_q[cnt_q] ? {{(OUT_MAN_WIDTH-IN_MAN_WIDTH){man_q[i][IN_MAN_WIDTH-1]}}, man_q[i]}
                                 : '0);
    end
  end

`ifdef DEQUANT_ZERO_SKIP_EN
  // Bits below the current one are all zero: the rest of the product is just a left shift.
  logic [SCALE_WIDTH-1:0] low_mask;
  assign low_mask = (SCALE_WIDTH'(1) << cnt_q) - SCALE_WIDTH'(1);
  assign skip     = ((scale_q & low_mask) == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      scale_q <= '0;
      cnt_q   <= '0;
      sign_q  <= '0;
      for (int i = 0; i < NUM_LANE; i++) begin
        man_q[i] <= '0;
        exp_q[i] <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            scale_q <= scale;
            cnt_q   <= cnt_d;
            sign_q  <= in_sign ^ {NUM_LANE{scale_sign}};
            for (int i = 0; i < NUM_LANE; i++) begin
              man_q[i] <= in_man[i*IN_MAN_WIDTH +: IN_MAN_WIDTH];
              exp_q[i] <= OUT_EXP_WIDTH'(in_exp[i*IN_EXP_WIDTH +: IN_EXP_WIDTH]);
              acc_q[i] <= '0;
            end
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NUM_LANE; i++)
            acc_q[i] <= skip ? (acc_d[i] << cnt_q) : acc_d[i];
          cnt_q <= cnt_q - CW'(1);
          if (skip || cnt_q == '0)
            state_q <= DONE;
        end
        DONE: begin
          if (out_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sign  = sign_q;

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_pack
    assign out_man[g*OUT_MAN_WIDTH +: OUT_MAN_WIDTH] = acc_q[g];
    assign out_exp[g*OUT_EXP_WIDTH +: OUT_EXP_WIDTH] = exp_q[g];
  end

endmodule

// File: tb/tb_dequant_bs_array.sv
// Directed bench for dequant_bs_array: table of single-bundle vectors plus
// backpressure, back-to-back and reset-abort sequences.
module tb_dequant_bs_array;

  localparam int NL  = 4;
  localparam int IEW = 6;
  localparam int IMW = 15;
  localparam int SW  = 8;
  localparam int OEW = 6;
  localparam int OMW = 23;
  localparam int PW  = 4;
  localparam int MW  = NL * IMW;
  localparam int EW  = NL * IEW;
  localparam int NV  = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [SW-1:0]     scale;
  logic              scale_sign;
  logic [PW-1:0]     scale_prec;
  logic [EW-1:0]     in_exp;
  logic [MW-1:0]     in_man;
  logic [NL-1:0]     in_sign;
  logic              out_valid;
  logic              out_ready;
  logic [NL*OEW-1:0] out_exp;
  logic [NL*OMW-1:0] out_man;
  logic [NL-1:0]     out_sign;
  logic              busy;

  int vecCount  = 0;
  int missCount = 0;

  dequant_bs_array #(
    .NUM_LANE(NL), .IN_EXP_WIDTH(IEW), .IN_MAN_WIDTH(IMW),
    .SCALE_WIDTH(SW), .OUT_EXP_WIDTH(OEW), .OUT_MAN_WIDTH(OMW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .scale(scale), .scale_sign(scale_sign), .scale_prec(scale_prec),
    .in_exp(in_exp), .in_man(in_man), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp),
    .out_man(out_man), .out_sign(out_sign), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0]            scale;
    logic                     ssign;
    logic [PW-1:0]            prec;
    logic [NL-1:0][IMW-1:0]   man;
    logic [NL-1:0]            isign;
    logic [NL-1:0][IEW-1:0]   exp;
    logic [NL-1:0][OMW-1:0]   res;
    logic [NL-1:0]            osign;
    int                       latFull;
    int                       latSkip;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mkVec(input int sc, ss, pr, m0, m1, m2, m3, is,
                                 e0, e1, e2, e3, r0, r1, r2, r3, os, lf, ls);
    vec_t v;
    v.scale  = SW'(sc);
    v.ssign  = 1'(ss);
    v.prec   = PW'(pr);
    v.man[0] = IMW'(m0); v.man[1] = IMW'(m1); v.man[2] = IMW'(m2); v.man[3] = IMW'(m3);
    v.isign  = NL'(is);
    v.exp[0] = IEW'(e0); v.exp[1] = IEW'(e1); v.exp[2] = IEW'(e2); v.exp[3] = IEW'(e3);
    v.res[0] = OMW'(r0); v.res[1] = OMW'(r1); v.res[2] = OMW'(r2); v.res[3] = OMW'(r3);
    v.osign  = NL'(os);
    v.latFull = lf;
    v.latSkip = ls;
    return v;
  endfunction

  function automatic int expLat(input int idx);
`ifdef DEQUANT_ZERO_SKIP_EN
    return vecs[idx].latSkip;
`else
    return vecs[idx].latFull;
`endif
  endfunction

  function automatic int manOf(input int lane);
    return int'($signed(out_man[lane*OMW +: OMW]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    vecCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic scramble();
    scale      = SW'($urandom());
    scale_sign = 1'($urandom());
    scale_prec = PW'($urandom());
    in_man     = MW'({$urandom(), $urandom()});
    in_exp     = EW'($urandom());
    in_sign    = NL'($urandom());
  endtask

  task automatic applyStimulus(input int idx);
    scale      = vecs[idx].scale;
    scale_sign = vecs[idx].ssign;
    scale_prec = vecs[idx].prec;
    in_man     = vecs[idx].man;
    in_exp     = vecs[idx].exp;
    in_sign    = vecs[idx].isign;
    in_valid   = 1'b1;
  endtask

  task automatic waitForDone(input int maxCycles, output int lat);
    lat = 0;
    while (!out_valid && lat < maxCycles) begin
      tick();
      lat++;
    end
  endtask

  task automatic checkOutput(input int idx);
    for (int i = 0; i < NL; i++) begin
      check($sformatf("v%0d_man%0d", idx, i), manOf(i), $signed(vecs[idx].res[i]));
      check($sformatf("v%0d_exp%0d", idx, i), out_exp[i*OEW +: OEW], vecs[idx].exp[i]);
    end
    check($sformatf("v%0d_sign", idx), out_sign, vecs[idx].osign);
    check($sformatf("v%0d_valid", idx), out_valid, 1);
  endtask

  task automatic runVector(input int idx);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("v%0d_ready", idx), in_ready, 1);
    applyStimulus(idx);
    tick();
    in_valid = 1'b0;
    scramble();
    check($sformatf("v%0d_busy", idx), busy, 1);
    waitForDone(30, lat);
    check($sformatf("v%0d_latency", idx), lat, expLat(idx));
    checkOutput(idx);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("v%0d_idle_valid", idx), out_valid, 0);
    check($sformatf("v%0d_idle_ready", idx), in_ready, 1);
    check($sformatf("v%0d_held_man0", idx), manOf(0), $signed(vecs[idx].res[0]));
  endtask

  function automatic int b2bLane0(input int k);
    return 1000 * (k + 1) - 7;
  endfunction

  function automatic int b2bLane3(input int k);
    return -5 * (k + 1);
  endfunction

  task automatic setB2b(input int k);
    in_man = {IMW'(b2bLane3(k)), IMW'(k), IMW'(k), IMW'(b2bLane0(k))};
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int lastAcc;
    int k;
    int pend;
    int nRes;
    logic accNow;
    logic seenValid;

    vecs[0] = mkVec(11, 0, 4, 5, -3, 0, 16383, 4'b1010, 1, 2, 3, 63,
                    55, -33, 0, 180213, 4'b1010, 4, 4);
    vecs[1] = mkVec(255, 1, 0, -16384, -16384, -16384, -16384, 4'b0000, 0, 5, 10, 15,
                    -4177920, -4177920, -4177920, -4177920, 4'b1111, 8, 8);
    vecs[2] = mkVec(255, 1, 12, -16384, -16384, -16384, -16384, 4'b0101, 7, 7, 7, 7,
                    -4177920, -4177920, -4177920, -4177920, 4'b1010, 8, 8);
    vecs[3] = mkVec(128, 0, 8, 3, 3, 3, 3, 4'b0011, 9, 9, 9, 9,
                    384, 384, 384, 384, 4'b0011, 8, 1);
    vecs[4] = mkVec(0, 1, 5, 7, -7, 100, -1, 4'b0110, 1, 1, 1, 1,
                    0, 0, 0, 0, 4'b1001, 5, 1);
    vecs[5] = mkVec(255, 0, 1, -1, 2, -16384, 16383, 4'b1111, 62, 61, 60, 59,
                    -1, 2, -16384, 16383, 4'b1111, 1, 1);
    vecs[6] = mkVec(244, 1, 3, 1, -2, 3, -4, 4'b1000, 10, 20, 30, 40,
                    4, -8, 12, -16, 4'b0111, 3, 1);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    scale = '0; scale_sign = 1'b0; scale_prec = '0;
    in_man = '0; in_exp = '0; in_sign = '0;

    // Reset state.
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_man", (out_man == '0), 1);
    check("rst_out_exp", (out_exp == '0), 1);
    check("rst_out_sign", out_sign, 0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);

    for (int v = 0; v < NV; v++) runVector(v);

    // Backpressure: DONE held while inputs churn, then no same-cycle bypass.
    applyStimulus(0);
    tick();
    in_valid = 1'b0;
    waitForDone(30, lat);
    check("bp_latency", lat, expLat(0));
    for (int c = 0; c < 5; c++) begin
      scramble();
      in_valid = 1'(c & 1);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_man3", manOf(3), 180213);
      check("bp_man1", manOf(1), -33);
      check("bp_sign", out_sign, 4'b1010);
    end
    applyStimulus(6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_busy", busy, 0);
    tick();
    in_valid = 1'b0;
    check("bp_next_busy", busy, 1);
    waitForDone(30, lat);
    check("bp_next_latency", lat, expLat(6));
    checkOutput(6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back at P=2: one accept every four cycles.
    scale = 8'd3; scale_prec = 4'd2; scale_sign = 1'b0; in_sign = '0; in_exp = '0;
    k = 0;
    setB2b(0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    lastAcc = -1; pend = 0; nRes = 0;
    for (int c = 0; c < 20; c++) begin
      accNow = in_valid && in_ready;
      tick();
      if (accNow) begin
        if (lastAcc >= 0) check("b2b_period", c - lastAcc, 4);
        lastAcc = c;
        pend = k;
        k++;
        setB2b(k);
      end
      if (out_valid) begin
        check("b2b_man0", manOf(0), 3 * b2bLane0(pend));
        check("b2b_man3", manOf(3), 3 * b2bLane3(pend));
        nRes++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_result_count", nRes, 5);
    tick();

    // Reset on the second RUN cycle of a P=8 job aborts it.
    scale = 8'd255; scale_prec = 4'd8; scale_sign = 1'b1;
    in_man = {IMW'(5), IMW'(5), IMW'(5), IMW'(5)};
    in_exp = {IEW'(33), IEW'(33), IEW'(33), IEW'(33)};
    in_sign = 4'b0101;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_man", (out_man == '0), 1);
    check("abort_exp", (out_exp == '0), 1);
    check("abort_sign", out_sign, 0);
    reset = 1'b0;
    #1;
    check("abort_release_ready", in_ready, 1);
    seenValid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seenValid = seenValid | out_valid;
    end
    check("abort_no_valid", seenValid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
